// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Types and constants shared by the operand-2 shifter slice.
//               Provides the shift-type encoding, the carry-flag position in
//               NZCV, the ALU command width and a 32-bit rotate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Encoding matches the 2-bit instruction field directly.
  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  // Position of C inside the NZCV nibble.
  localparam int FLAG_C_IDX = 1;

  // Width of the ALU command that rides alongside the operands.
  localparam int CMD_W = 5;

  // Rotate right. A rotate by zero yields the input because the two halves
  // overlap exactly.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (5'd0 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand2_shifter_if.sv
`default_nettype none
// ============================================================================
// Interface   : operand2_shifter_if
// Description : Operand and handshake bundle for the operand-2 shifter.
//   Upstream -> stage : in_valid, stall, op_is_imm, imm8, rot4, rm_val,
//                       shift_type, shift_by_reg, shamt5, rs_val, flags,
//                       src1_in, cmd_in
//   Stage -> upstream : in_ready
//   Stage -> ALU      : src2, src2shift_carry, was_shifted, src1, CTRL_cmd,
//                       out_valid
//   Modports: slave = the shifter stage, master = whoever drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand2_shifter_if #(
  parameter int WIDTH = 32
);
  import cpu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               stall;
  logic               op_is_imm;
  logic [7:0]         imm8;
  logic [3:0]         rot4;
  logic [WIDTH-1:0]   rm_val;
  logic [1:0]         shift_type;
  logic               shift_by_reg;
  logic [4:0]         shamt5;
  logic [WIDTH-1:0]   rs_val;
  logic [3:0]         flags;
  logic [WIDTH-1:0]   src1_in;
  logic [CMD_W-1:0]   cmd_in;

  logic [WIDTH-1:0]   src2;
  logic               src2shift_carry;
  logic               was_shifted;
  logic [WIDTH-1:0]   src1;
  logic [CMD_W-1:0]   CTRL_cmd;
  logic               out_valid;

  modport slave (
    input  in_valid, stall, op_is_imm, imm8, rot4, rm_val, shift_type,
           shift_by_reg, shamt5, rs_val, flags, src1_in, cmd_in,
    output in_ready, src2, src2shift_carry, was_shifted, src1, CTRL_cmd,
           out_valid
  );

  modport master (
    output in_valid, stall, op_is_imm, imm8, rot4, rm_val, shift_type,
           shift_by_reg, shamt5, rs_val, flags, src1_in, cmd_in,
    input  in_ready, src2, src2shift_carry, was_shifted, src1, CTRL_cmd,
           out_valid
  );

endinterface
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ============================================================================
// Module      : shift_core
// Description : Combinational ARM barrel shifter.
//   rm         in  32  value to shift
//   shift_type in   2  LSL / LSR / ASR / ROR
//   amount     in   8  shift amount (only [4:0] used when imm_mode=1)
//   imm_mode   in   1  1 = 5-bit instruction-encoded amount (0 means 32 or
//                      RRX), 0 = register amount (0 means no shift)
//   carry_in   in   1  current C flag
//   result     out 32  shifted value
//   carry      out  1  shifter carry-out
//   shifted    out  1  carry was produced by the shifter, not passed through
// Revision    : 1.0 - initial release
// ============================================================================
module shift_core
  import cpu_pkg::*;
(
  input  logic [31:0] rm,
  input  shift_t      shift_type,
  input  logic [7:0]  amount,
  input  logic        imm_mode,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry,
  output logic        shifted
);

  logic [4:0]  w_n5;
  logic [4:0]  w_nm1;
  logic [31:0] w_lsl;
  logic [31:0] w_lsr;
  logic [31:0] w_asr;
  logic [31:0] w_ror;
  logic [31:0] w_lsl_prev;
  logic [31:0] w_rsh_prev;
  logic        w_lsl_c;
  logic        w_rsh_c;
  logic        w_lt32;
  logic        w_eq32;

  assign w_n5  = amount[4:0];
  assign w_nm1 = w_n5 - 5'd1;

  assign w_lsl = rm << w_n5;
  assign w_lsr = rm >> w_n5;
  assign w_asr = 32'($signed(rm) >>> w_n5);
  assign w_ror = ror32(rm, w_n5);

  // The last bit shifted out is the edge bit of a shift one step shorter;
  // this avoids a variable bit-select with a computed 32-n index.
  assign w_lsl_prev = rm << w_nm1;
  assign w_rsh_prev = rm >> w_nm1;
  assign w_lsl_c    = w_lsl_prev[31];
  assign w_rsh_c    = w_rsh_prev[0];

  assign w_lt32 = (amount[7:5] == 3'd0);
  assign w_eq32 = (amount == 8'd32);

  always_comb begin
    result  = rm;
    carry   = carry_in;
    shifted = 1'b0;
    if (imm_mode) begin
      shifted = 1'b1;
      case (shift_type)
        LSL: begin
          if (w_n5 == 5'd0) begin
            shifted = 1'b0;
          end else begin
            result = w_lsl;
            carry  = w_lsl_c;
          end
        end
        LSR: begin
          if (w_n5 == 5'd0) begin
            result = '0;
            carry  = rm[31];
          end else begin
            result = w_lsr;
            carry  = w_rsh_c;
          end
        end
        ASR: begin
          if (w_n5 == 5'd0) begin
            result = {32{rm[31]}};
            carry  = rm[31];
          end else begin
            result = w_asr;
            carry  = w_rsh_c;
          end
        end
        ROR: begin
          if (w_n5 == 5'd0) begin
            // RRX: rotate through carry by one.
            result = {carry_in, rm[31:1]};
            carry  = rm[0];
          end else begin
            result = w_ror;
            carry  = w_rsh_c;
          end
        end
        default: ;
      endcase
    end else if (amount != 8'd0) begin
      shifted = 1'b1;
      case (shift_type)
        LSL: begin
          if (w_lt32) begin
            result = w_lsl;
            carry  = w_lsl_c;
          end else begin
            result = '0;
            carry  = w_eq32 ? rm[0] : 1'b0;
          end
        end
        LSR: begin
          if (w_lt32) begin
            result = w_lsr;
            carry  = w_rsh_c;
          end else begin
            result = '0;
            carry  = w_eq32 ? rm[31] : 1'b0;
          end
        end
        ASR: begin
          if (w_lt32) begin
            result = w_asr;
            carry  = w_rsh_c;
          end else begin
            result = {32{rm[31]}};
            carry  = rm[31];
          end
        end
        ROR: begin
          // A nonzero multiple of 32 leaves the value in place but still
          // reports bit 31 as the carry.
          if (w_n5 == 5'd0) begin
            result = rm;
            carry  = rm[31];
          end else begin
            result = w_ror;
            carry  = w_rsh_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand2_shifter.sv
`default_nettype none
// ============================================================================
// Module      : operand2_shifter
// Description : Registered operand-2 stage feeding the ALU. Selects between a
//               rotated 8-bit immediate and a shifted register, then registers
//               src2/carry/was_shifted together with src1 and the ALU command.
//   CLOCK_50  in   1  clock, all state on rising edge
//   reset     in   1  synchronous active-high reset
//   bus       slave operand2_shifter_if (handshake, operands, ALU outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module operand2_shifter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  operand2_shifter_if.slave     bus
);

  logic [31:0]       w_sh_in;
  shift_t            w_sh_type;
  logic [7:0]        w_sh_amt;
  logic              w_sh_imm_mode;
  logic [31:0]       w_sh_result;
  logic              w_sh_carry;
  logic              w_sh_shifted;
  logic              w_unused_bits;

  logic [WIDTH-1:0]  r_src2;
  logic              r_carry;
  logic              r_shifted;
  logic [WIDTH-1:0]  r_src1;
  logic [CMD_W-1:0]  r_cmd;
  logic              r_valid;

  // A rotated immediate is a register-style ROR by 2*rot4: amount 0 passes
  // C through, any other even amount gives carry = result[31].
  always_comb begin
    w_sh_in       = bus.rm_val;
    w_sh_type     = shift_t'(bus.shift_type);
    w_sh_amt      = bus.shift_by_reg ? bus.rs_val[7:0] : {3'b000, bus.shamt5};
    w_sh_imm_mode = !bus.shift_by_reg;
    if (bus.op_is_imm) begin
      w_sh_in       = {24'd0, bus.imm8};
      w_sh_type     = ROR;
      w_sh_amt      = {3'b000, bus.rot4, 1'b0};
      w_sh_imm_mode = 1'b0;
    end
  end

  shift_core u_shift_core (
    .rm         (w_sh_in),
    .shift_type (w_sh_type),
    .amount     (w_sh_amt),
    .imm_mode   (w_sh_imm_mode),
    .carry_in   (bus.flags[FLAG_C_IDX]),
    .result     (w_sh_result),
    .carry      (w_sh_carry),
    .shifted    (w_sh_shifted)
  );

  // Only C and the low byte of the amount register matter here.
  assign w_unused_bits = ^{bus.flags[3:2], bus.flags[0], bus.rs_val[31:8]};

  // Data registers load whenever not stalled, valid or not; the consumer
  // qualifies with out_valid.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_src2    <= '0;
      r_carry   <= 1'b0;
      r_shifted <= 1'b0;
      r_src1    <= '0;
      r_cmd     <= '0;
      r_valid   <= 1'b0;
    end else if (!bus.stall) begin
      r_src2    <= w_sh_result;
      r_carry   <= w_sh_carry;
      r_shifted <= w_sh_shifted;
      r_src1    <= bus.src1_in;
      r_cmd     <= bus.cmd_in;
      r_valid   <= bus.in_valid;
    end
  end

  assign bus.in_ready        = !bus.stall;
  assign bus.src2            = r_src2;
  assign bus.src2shift_carry = r_carry;
  assign bus.was_shifted     = r_shifted;
  assign bus.src1            = r_src1;
  assign bus.CTRL_cmd        = r_cmd;
  assign bus.out_valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_operand2_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand2_shifter
// Description : Self-checking bench for operand2_shifter. A behavioural
//               model computes every shift with wide arithmetic and a
//               one-deep pipeline image; directed cases are followed by a
//               random sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand2_shifter;
  import cpu_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #10 CLOCK_50 = ~CLOCK_50;

  operand2_shifter_if bus ();

  operand2_shifter #(.WIDTH(32)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] e_src2;
  logic        e_c;
  logic        e_s;
  logic [31:0] e_src1;
  logic [4:0]  e_cmd;
  logic        e_v;

  // {shifted, carry, result} for a register-style amount n (0 = no shift).
  function automatic logic [33:0] ref_reg(input logic [1:0] t, input logic [31:0] rm,
                                          input int n, input logic cin);
    logic [63:0] v;
    logic [31:0] r;
    logic        c;
    if (n == 0) return {1'b0, cin, rm};
    case (t)
      2'd0: begin v = {32'd0, rm} << n; r = v[31:0];  c = v[32]; end
      2'd1: begin v = {rm, 32'd0} >> n; r = v[63:32]; c = v[31]; end
      2'd2: begin v = 64'($signed({rm, 32'd0}) >>> n); r = v[63:32]; c = v[31]; end
      default: begin v = {rm, rm} >> (n % 32); r = v[31:0]; c = r[31]; end
    endcase
    return {1'b1, c, r};
  endfunction

  function automatic logic [33:0] ref_op(input logic is_imm, input logic [7:0] i8,
                                         input logic [3:0] r4, input logic [31:0] rm,
                                         input logic [1:0] t, input logic by_reg,
                                         input logic [4:0] sh, input logic [31:0] rs,
                                         input logic cin);
    if (is_imm) return ref_reg(2'd3, {24'd0, i8}, 2 * int'(r4), cin);
    if (by_reg) return ref_reg(t, rm, int'(rs[7:0]), cin);
    if (sh != 5'd0) return ref_reg(t, rm, int'(sh), cin);
    case (t)
      2'd0:    return ref_reg(t, rm, 0, cin);
      2'd1,
      2'd2:    return ref_reg(t, rm, 32, cin);
      default: return {1'b1, rm[0], cin, rm[31:1]};
    endcase
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk32({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!bus.stall));
    chk32({tag, ".src2"}, bus.src2, e_src2);
    chk32({tag, ".carry"}, 32'(bus.src2shift_carry), 32'(e_c));
    chk32({tag, ".was_shifted"}, 32'(bus.was_shifted), 32'(e_s));
    chk32({tag, ".src1"}, bus.src1, e_src1);
    chk32({tag, ".cmd"}, 32'(bus.CTRL_cmd), 32'(e_cmd));
    chk32({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e_v));
  endtask

  // Advance one clock with the inputs currently on the bus, updating the
  // expected register image, then compare.
  task automatic cycle(input string tag);
    logic [33:0] m;
    m = ref_op(bus.op_is_imm, bus.imm8, bus.rot4, bus.rm_val, bus.shift_type,
               bus.shift_by_reg, bus.shamt5, bus.rs_val, bus.flags[1]);
    if (reset) begin
      e_src2 = '0; e_c = 0; e_s = 0; e_src1 = '0; e_cmd = '0; e_v = 0;
    end else if (!bus.stall) begin
      e_src2 = m[31:0]; e_c = m[32]; e_s = m[33];
      e_src1 = bus.src1_in; e_cmd = bus.cmd_in; e_v = bus.in_valid;
    end
    @(posedge CLOCK_50);
    #1;
    check_all(tag);
  endtask

  task automatic set_reg(input logic [1:0] t, input logic by_reg, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rm, input logic [3:0] fl);
    bus.op_is_imm = 0; bus.shift_type = t; bus.shift_by_reg = by_reg;
    bus.shamt5 = sh; bus.rs_val = rs; bus.rm_val = rm; bus.flags = fl;
  endtask

  task automatic set_imm(input logic [7:0] i8, input logic [3:0] r4, input logic [3:0] fl);
    bus.op_is_imm = 1; bus.imm8 = i8; bus.rot4 = r4; bus.flags = fl;
  endtask

  initial begin
    reset = 1;
    bus.in_valid = 0; bus.stall = 0; bus.op_is_imm = 0; bus.imm8 = 0; bus.rot4 = 0;
    bus.rm_val = 0; bus.shift_type = 0; bus.shift_by_reg = 0; bus.shamt5 = 0;
    bus.rs_val = 0; bus.flags = 0; bus.src1_in = 32'h1234_5678; bus.cmd_in = 5'h0A;
    cycle("reset");
    cycle("reset2");
    reset = 0;

    bus.in_valid = 1;
    set_reg(2'd0, 0, 5'd1, 0, 32'h8000_0001, 4'b0000);
    cycle("lsl1");
    chk32("lsl1.lit", bus.src2, 32'h0000_0002);
    chk32("lsl1.lit_c", 32'(bus.src2shift_carry), 32'd1);

    set_reg(2'd1, 0, 5'd0, 0, 32'h8000_0000, 4'b0000);
    cycle("lsr32");
    set_reg(2'd2, 1, 5'd0, 32'd40, 32'h8000_0000, 4'b0000);
    cycle("asr40");
    chk32("asr40.lit", bus.src2, 32'hFFFF_FFFF);
    set_reg(2'd3, 0, 5'd0, 0, 32'h0000_0001, 4'b0010);
    cycle("rrx");
    chk32("rrx.lit", bus.src2, 32'h8000_0000);
    set_reg(2'd3, 1, 5'd0, 32'd32, 32'h8000_0000, 4'b0000);
    cycle("ror32");
    set_reg(2'd0, 1, 5'd0, 32'd32, 32'h0000_0001, 4'b0000);
    cycle("lslr32");
    set_reg(2'd1, 1, 5'd0, 32'd33, 32'hFFFF_FFFF, 4'b0000);
    cycle("lsrr33");
    set_reg(2'd1, 1, 5'd0, 32'hFFFF_FF00, 32'hDEAD_BEEF, 4'b0010);
    cycle("reg0");
    set_reg(2'd0, 0, 5'd0, 0, 32'hCAFE_F00D, 4'b0000);
    cycle("lsl0");
    set_imm(8'hFF, 4'd4, 4'b0000);
    cycle("imm_rot");
    chk32("imm_rot.lit", bus.src2, 32'hFF00_0000);
    set_imm(8'h05, 4'd0, 4'b0010);
    cycle("imm_norot");
    chk32("imm_norot.lit_s", 32'(bus.was_shifted), 32'd0);

    // Stall: A accepted, B held off for three cycles.
    set_reg(2'd1, 0, 5'd4, 0, 32'hA5A5_0000, 4'b0000);
    bus.src1_in = 32'hAAAA_AAAA; bus.cmd_in = 5'h11;
    cycle("stallA");
    set_reg(2'd2, 0, 5'd8, 0, 32'hF000_000F, 4'b0000);
    bus.src1_in = 32'hBBBB_BBBB; bus.cmd_in = 5'h12;
    bus.stall = 1;
    cycle("stall1"); cycle("stall2"); cycle("stall3");
    chk32("stall.hold", bus.src1, 32'hAAAA_AAAA);
    bus.stall = 0;
    cycle("stallB");
    chk32("stallB.lit", bus.src1, 32'hBBBB_BBBB);

    // Reset beats stall while a valid op is held.
    bus.stall = 1; reset = 1;
    cycle("rst_stall");
    reset = 0; bus.stall = 0;
    set_reg(2'd0, 0, 5'd3, 0, 32'h0000_0011, 4'b0000);
    cycle("post_rst");

    for (int i = 0; i < 300; i++) begin
      bus.in_valid     = 1'($urandom);
      bus.stall        = ($urandom_range(0, 3) == 0);
      reset            = ($urandom_range(0, 39) == 0);
      bus.op_is_imm    = ($urandom_range(0, 3) == 0);
      bus.imm8         = 8'($urandom);
      bus.rot4         = 4'($urandom);
      bus.rm_val       = $urandom;
      bus.shift_type   = 2'($urandom);
      bus.shift_by_reg = 1'($urandom);
      bus.shamt5       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 3))
        0:       bus.rs_val = $urandom_range(0, 40);
        1:       bus.rs_val = {$urandom_range(0, 7), 5'd0};
        default: bus.rs_val = $urandom;
      endcase
      bus.flags        = 4'($urandom);
      bus.src1_in      = $urandom;
      bus.cmd_in       = 5'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
